// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction RAM.
// It receives a framed byte stream from the host link and assembles
// 32-bit little-endian words. Each word is written sequentially into
// the instruction RAM. The CPU is held in reset until a complete,
// valid image has been loaded.
// Frame layout: SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes, then a CKSUM byte.
// The CKSUM byte is present only when IMEM_LOADER_CKSUM_EN is defined.
// It is the 8-bit sum of all data bytes.
module imem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LEN_LO    = 3'd1;
    localparam logic [2:0] S_LEN_HI    = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
`ifdef IMEM_LOADER_CKSUM_EN
    localparam logic [2:0] S_CKSUM     = 3'd4;
`endif
    localparam logic [2:0] S_WAIT_DONE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    // Largest legal word count, widened so a 16-bit length compares cleanly.
    localparam logic [31:0]           MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]            state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic [ADDR_WIDTH:0]   words_written_q, words_written_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]            cksum_q, cksum_d;
`endif

    logic        accept;
    logic [15:0] len_full;

    // The loader accepts bytes only in the states that consume frame bytes.
    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM:                            byte_ready = 1'b1;
`endif
            default:                            byte_ready = 1'b0;
        endcase
    end

    assign accept   = byte_valid && byte_ready;
    assign len_full = {byte_data, len_q[7:0]};

    // Next-state logic for the frame parser, the word assembler and the write port.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d         = state_q;
        len_d           = len_q;
        byte_cnt_d      = byte_cnt_q;
        word_cnt_d      = word_cnt_q;
        asm_d           = asm_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        words_written_d = words_written_q;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum_d         = cksum_q;
`endif

        // A write issued last cycle has now committed; advance the address.
        if (wr_en_q) begin
            wr_addr_d       = wr_addr_q + ADDR_ONE;
            words_written_d = words_written_q + CNT_ONE;
        end

        if (restart) begin
            state_d         = S_IDLE;
            wr_en_d         = 1'b0;
            wr_addr_d       = '0;
            words_written_d = '0;
        end else if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d         = S_LEN_LO;
                        byte_cnt_d      = 2'd0;
                        word_cnt_d      = 16'd0;
                        wr_addr_d       = '0;
                        words_written_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
                        cksum_d         = 8'd0;
`endif
                    end
                end
                S_LEN_LO: begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d[15:8] = byte_data;
                    if (len_full == 16'd0 || {16'd0, len_full} > MAX_WORDS)
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA;
                end
                S_DATA: begin
`ifdef IMEM_LOADER_CKSUM_EN
                    cksum_d = cksum_q + byte_data;
`endif
                    // Bytes arrive LSB first, so shift right.
                    // After three bytes, asm_q holds {b2, b1, b0}.
                    asm_d      = {byte_data, asm_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = {byte_data, asm_q};
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CKSUM_EN
                            state_d = S_CKSUM;
`else
                            state_d = S_WAIT_DONE;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    state_d = (byte_data == cksum_q) ? S_WAIT_DONE : S_ERROR;
                end
`endif
                default: ;
            endcase
        end else if (state_q == S_WAIT_DONE) begin
            // Byte acceptance is impossible here; this state only lets the final write land.
            state_d = S_DONE;
        end
    end

    // State register; rst discards any partial word and returns to the idle image state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            len_q           <= 16'd0;
            byte_cnt_q      <= 2'd0;
            word_cnt_q      <= 16'd0;
            asm_q           <= 24'd0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= 32'd0;
            words_written_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q         <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
            state_q         <= state_d;
            len_q           <= len_d;
            byte_cnt_q      <= byte_cnt_d;
            word_cnt_q      <= word_cnt_d;
            asm_q           <= asm_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            words_written_q <= words_written_d;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q         <= cksum_d;
`endif
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign words_written = words_written_q;
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERROR);
    assign cpu_hold      = (state_q != S_DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream from the host link and assembles it into 32-bit little-endian instruction words.
- Writes each word sequentially into the 1024x32 instruction RAM that sits in place of the fixed program ROM.
- Holds the single-cycle CPU in reset (cpu_hold) until a complete, valid image is loaded.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction RAM (capacity 2^ADDR_WIDTH words)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
restart  in  1  synchronous pulse; returns to IDLE from any state
byte_valid  in  1  byte_data valid this cycle
byte_data  in  8  incoming byte
byte_ready  out  1  loader accepts byte; transfer occurs when byte_valid && byte_ready
wr_en  out  1  one-cycle RAM write strobe
wr_addr  out  ADDR_WIDTH  RAM word address
wr_data  out  32  RAM write data
cpu_hold  out  1  CPU reset hold; high until DONE
done  out  1  image loaded (sticky)
error  out  1  frame error (sticky)
words_written  out  ADDR_WIDTH+1  count of words written this frame

Behaviour:
- Reset values: byte_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, words_written=0, state=IDLE.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), 4N data bytes (LSB first per word), CKSUM (when feature enabled).
- States:
  - IDLE: accepted bytes not equal to SYNC_BYTE are discarded. SYNC_BYTE -> LEN_LO, clears byte/word counters, checksum, wr_addr and words_written.
  - LEN_LO: latch low byte -> LEN_HI.
  - LEN_HI: latch high byte. If N==0 or N>2^ADDR_WIDTH -> ERROR, else -> DATA.
  - DATA: shift bytes into word assembler, byte k into bits [8k+7:8k]; 8-bit checksum += byte. When the 4th byte is accepted in cycle C:
    - wr_en=1 in cycle C+1 with registered wr_data/wr_addr; words_written increments at the end of C+1.
    - wr_addr increments after the write.
    - If this was word N, go to CKSUM (feature on) or WAIT_DONE (feature off).
  - CKSUM: accept one byte. If it equals the running sum mod 256 -> WAIT_DONE, else -> ERROR. The final word's write still completes.
  - WAIT_DONE: one cycle, guarantees the final write has committed -> DONE.
  - DONE: done=1, cpu_hold=0, byte_ready=0. Sticky.
  - ERROR: error=1, cpu_hold=1, byte_ready=0. Sticky. RAM contents are undefined.
- byte_ready=1 in IDLE, LEN_LO, LEN_HI, DATA, CKSUM. byte_ready=0 in WAIT_DONE, DONE, ERROR.
- Throughput: one byte per cycle, no stalls. A byte accepted in cycle C+1 while wr_en is high is handled normally.
- restart (any state, takes priority over byte acceptance): next state IDLE. Clears done, error, wr_addr, words_written. Asserts cpu_hold. Any pending wr_en is suppressed.
- rst mid-frame: immediate return to reset values. The partial word is discarded and never written.
- byte_valid low: state is held; gaps are allowed anywhere in a frame.
- N==2^ADDR_WIDTH: last write at address 2^ADDR_WIDTH-1. wr_addr wraps to 0 and is unused; words_written = 2^ADDR_WIDTH.

Optional Feature:
- IMEM_LOADER_CKSUM_EN defined:
  - CKSUM state present; the trailing checksum byte is required.
  - A mismatch forces ERROR.
- Not defined:
  - No CKSUM state; the last data word goes straight to WAIT_DONE.
  - A byte following the frame is not accepted (byte_ready=0).
  - error is asserted only for an invalid length.

Test Plan:
- Reset, then frame A5 01 00 93 04 10 00 CK=0xA7 -> one wr_en at addr 0, data 32'h00100493; done=1 and cpu_hold=0 two cycles after the write cycle; words_written=1.
- Noise bytes 00 FF 5A before A5, then 2-word frame (00100493, 0100006F) with correct checksum -> noise ignored; writes at addr 0,1 with those values; done=1.
- Frame with N=2 and checksum off by one (feature on) -> both words written, then error=1, done=0, cpu_hold stays 1, byte_ready=0.
- Length bytes 00 00, and separately 01 04 (N=1025) -> error=1 immediately after LEN_HI; no wr_en ever asserted.
- Assert rst after 2 data bytes of word 1 of a 3-word frame, then send a full valid 1-word frame -> only the new word written at addr 0; done=1.
- byte_valid toggled 1/0 every cycle across a 1024-word frame -> 1024 writes at addrs 0..1023 in order; words_written=1024; done=1. Then restart pulse -> done=0, cpu_hold=1, state IDLE.
